regfile_mp: RTL

//  Parametrised multi-port general-purpose register file, successor to the single-write MIPS regfile.

---
 rtl/regfile_mp.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port general-purpose register file
//
// NRP combinational read ports and two synchronous write ports for a
// dual-issue datapath. Write slot 0 is the older instruction and slot 1 is the
// younger one; when both slots write the same entry, slot 1 wins. After every
// reset a sequential sweep clears all DEPTH entries. While the sweep runs,
// busy is high, writes are ignored and every read port returns zero.
//
// Parameters
//   DATA_W   data width in bits
//   ADDR_W   address width, DEPTH = 2**ADDR_W
//   NRP      number of read ports (1..8)
//   ZERO_R0  1: entry 0 reads as zero and writes to it are dropped
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset (restarts the clear sweep)
//   busy           clear sweep in progress (registered)
//   we0/wa0/wd0    write slot 0 (older): enable, address, data
//   we1/wa1/wd1    write slot 1 (younger): enable, address, data
//   ra             packed read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd             packed read data, port i = rd[i*DATA_W +: DATA_W]
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a read port whose address matches an enabled write in the
//   same cycle returns that write data (slot 1 data if both slots match).
//   When undefined, a write becomes visible on the following cycle.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRP     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NRP*ADDR_W-1:0]    ra,
    output logic [NRP*DATA_W-1:0]    rd
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                busy_q;
    logic [DATA_W-1:0]   rf_q [DEPTH];

    logic                wr0_ok_d;
    logic                wr1_ok_d;

    // Effective write enables: writes to entry 0 vanish when it is hardwired.
    always_comb begin
        wr0_ok_d = we0;
        wr1_ok_d = we1;
        if ((ZERO_R0 != 0) && (wa0 == '0)) begin
            wr0_ok_d = 1'b0;
        end else begin
            wr0_ok_d = we0;
        end
        if ((ZERO_R0 != 0) && (wa1 == '0)) begin
            wr1_ok_d = 1'b0;
        end else begin
            wr1_ok_d = we1;
        end
    end

    // Clear-sweep FSM and array update; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    rf_q[clr_cnt_q] <= '0;
                    clr_cnt_q       <= clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    // Slot 1 is assigned last so it wins on an address collision.
                    if (wr0_ok_d) begin
                        rf_q[wa0] <= wd0;
                    end
                    if (wr1_ok_d) begin
                        rf_q[wa1] <= wd1;
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign busy = busy_q;

    for (genvar g = 0; g < NRP; g++) begin : g_rd
        logic [ADDR_W-1:0] ra_p;
        logic [DATA_W-1:0] rd_p;

        assign ra_p = ra[g*ADDR_W +: ADDR_W];

        // Read mux: busy and hardwired entry 0 override everything else.
        always_comb begin
            rd_p = '0;
            if (busy_q) begin
                rd_p = '0;
            end else if ((ZERO_R0 != 0) && (ra_p == '0)) begin
                rd_p = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr1_ok_d && (wa1 == ra_p)) begin
                rd_p = wd1;
            end else if (wr0_ok_d && (wa0 == ra_p)) begin
                rd_p = wd0;
`endif
            end else begin
                rd_p = rf_q[ra_p];
            end
        end

        assign rd[g*DATA_W +: DATA_W] = rd_p;
    end

endmodule
